// File: rtl/lorenz_frame_pkg.sv
// Shared definitions for the Lorenz oscillator frame transmitter.
//   HDR0_BYTE / HDR1_BYTE : frame header bytes
//   state_e               : transmit FSM state encoding
//   data_bytes(width)     : x/y/z payload bytes for a given sample width
//   frame_len(width)      : total frame bytes (header + payload + checksum)
package lorenz_frame_pkg;

  localparam logic [7:0] HDR0_BYTE = 8'hA5;
  localparam logic [7:0] HDR1_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

  function automatic int unsigned data_bytes(input int unsigned width);
    return 3 * (width / 8);
  endfunction

  function automatic int unsigned frame_len(input int unsigned width);
    return data_bytes(width) + 3;
  endfunction

endpackage

// File: rtl/lorenz_frame_ser.sv
// Payload serialiser: holds the captured x/y/z sample, walks it MSB-first one
// byte per advance and keeps the running XOR checksum of the bytes sent.
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   load_i              : capture xn/yn/zn, rewind byte index, clear checksum
//   adv_i               : current payload byte was transferred
//   xn_i, yn_i, zn_i    : sample inputs (only looked at on load_i)
//   byte_o              : payload byte at the current index
//   csum_o              : XOR of all payload bytes transferred since load
//   last_o              : current index is the final payload byte
module lorenz_frame_ser
  import lorenz_frame_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [Width-1:0] xn_i,
  input  logic [Width-1:0] yn_i,
  input  logic [Width-1:0] zn_i,
  output logic [7:0]       byte_o,
  output logic [7:0]       csum_o,
  output logic             last_o
);

  localparam int NB   = data_bytes(Width);
  localparam int IdxW = $clog2(NB);

  logic [3*Width-1:0] r_shadow;
  logic [3*Width-1:0] w_shifted;
  logic [IdxW-1:0]    r_idx;
  logic [7:0]         r_csum;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the shadow registers are plain flops (not a RAM), so they take the
  // async reset like the rest of the state and restart from a known zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_shadow <= '0;
      r_idx    <= '0;
      r_csum   <= '0;
    end else if (load_i) begin
      r_shadow <= {xn_i, yn_i, zn_i};
      r_idx    <= '0;
      r_csum   <= '0;
    end else if (adv_i) begin
      r_idx    <= r_idx + 1'b1;
      r_csum   <= r_csum ^ byte_o;
    end
  end

  // The shadow is never shifted in place; the selected byte is brought to the
  // top of a combinational copy so the captured sample stays intact all frame.
  assign w_shifted = r_shadow << {r_idx, 3'b000};
  assign byte_o    = w_shifted[3*Width-1 -: 8];
  assign csum_o    = r_csum;
  assign last_o    = (r_idx == IdxW'(NB - 1));

endmodule

// File: rtl/lorenz_frame_tx.sv
// Lorenz oscillator frame transmitter. Decimates accepted x/y/z samples and
// sends each selected one as A5 5A x y z csum over a valid/ready byte link.
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   start_i                 : enables sample capture; low clears decimation
//   sample_valid_i          : strobe for xn_i/yn_i/zn_i
//   xn_i, yn_i, zn_i        : oscillator state samples (Width bits each)
//   tx_data_o, tx_valid_o   : frame byte and its valid flag
//   tx_ready_i              : sink ready; transfer when valid & ready
//   busy_o                  : a frame is in progress
//   drop_cnt_o              : saturating count of selected samples lost
module lorenz_frame_tx
  import lorenz_frame_pkg::*;
#(
  parameter int Width = 32,
  parameter int Decim = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sample_valid_i,
  input  logic [Width-1:0] xn_i,
  input  logic [Width-1:0] yn_i,
  input  logic [Width-1:0] zn_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic [15:0]      drop_cnt_o
);

  localparam int DecW = (Decim > 1) ? $clog2(Decim) : 1;

  state_e          r_state;
  state_e          w_next;
  logic [DecW-1:0] r_dec;
  logic [15:0]     r_drop;

  logic       w_accept;
  logic       w_select;
  logic       w_xfer;
  logic       w_can_capture;
  logic       w_capture;
  logic       w_drop;
  logic [7:0] w_byte;
  logic [7:0] w_csum;
  logic       w_last;

  assign w_accept = start_i & sample_valid_i;
  assign w_select = w_accept & (r_dec == '0);
  assign w_xfer   = tx_valid_o & tx_ready_i;

  // The checksum byte leaving frees the serialiser in the same edge, so a
  // sample selected then is captured and the next header follows back-to-back.
  assign w_can_capture = (r_state == ST_IDLE) | ((r_state == ST_CSUM) & w_xfer);
  assign w_capture     = w_select & w_can_capture;
  assign w_drop        = w_select & ~w_can_capture;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_dec   <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_next;
      if (!start_i) begin
        r_dec <= '0;
      end else if (w_accept) begin
        r_dec <= (r_dec == DecW'(Decim - 1)) ? '0 : r_dec + 1'b1;
      end
      if (w_drop && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next    = r_state;
    tx_data_o = 8'h00;
    unique case (r_state)
      ST_IDLE: begin
        if (w_capture) w_next = ST_HDR0;
      end
      ST_HDR0: begin
        tx_data_o = HDR0_BYTE;
        if (w_xfer) w_next = ST_HDR1;
      end
      ST_HDR1: begin
        tx_data_o = HDR1_BYTE;
        if (w_xfer) w_next = ST_DATA;
      end
      ST_DATA: begin
        tx_data_o = w_byte;
        if (w_xfer && w_last) w_next = ST_CSUM;
      end
      ST_CSUM: begin
        tx_data_o = w_csum;
        if (w_xfer) w_next = w_capture ? ST_HDR0 : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign tx_valid_o = (r_state != ST_IDLE);
  assign busy_o     = (r_state != ST_IDLE);
  assign drop_cnt_o = r_drop;

  lorenz_frame_ser #(
    .Width(Width)
  ) u_ser (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_capture),
    .adv_i  ((r_state == ST_DATA) & w_xfer),
    .xn_i   (xn_i),
    .yn_i   (yn_i),
    .zn_i   (zn_i),
    .byte_o (w_byte),
    .csum_o (w_csum),
    .last_o (w_last)
  );

endmodule

// File: tb/tb_lorenz_frame_tx.sv
// Directed self-checking bench for lorenz_frame_tx. A Decim=1 instance is the
// main target; a Decim=4 instance shares the inputs for the decimation test.
module tb_lorenz_frame_tx;
  import lorenz_frame_pkg::*;

  localparam int FL = frame_len(32);

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic        sample_valid_i;
  logic [31:0] xn_i, yn_i, zn_i;
  logic        tx_ready_i;

  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        busy_o;
  logic [15:0] drop_cnt_o;

  logic [7:0]  d4_data;
  logic        d4_valid;
  logic        d4_busy;
  logic [15:0] d4_drop;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_bytes [0:14];
  logic [7:0] mon4 [$];
  bit         mon_en = 1'b0;

  lorenz_frame_tx #(.Width(32), .Decim(1)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .sample_valid_i (sample_valid_i),
    .xn_i           (xn_i),
    .yn_i           (yn_i),
    .zn_i           (zn_i),
    .tx_data_o      (tx_data_o),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i),
    .busy_o         (busy_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  lorenz_frame_tx #(.Width(32), .Decim(4)) dut4 (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .sample_valid_i (sample_valid_i),
    .xn_i           (xn_i),
    .yn_i           (yn_i),
    .zn_i           (zn_i),
    .tx_data_o      (d4_data),
    .tx_valid_o     (d4_valid),
    .tx_ready_i     (tx_ready_i),
    .busy_o         (d4_busy),
    .drop_cnt_o     (d4_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bytes of the Decim=4 instance that transfer on the next rising edge.
  always @(negedge clk) begin
    if (mon_en && rst_i && d4_valid && tx_ready_i) mon4.push_back(d4_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    sample_valid_i = 1'b0;
    start_i = 1'b0;
    tx_ready_i = 1'b1;
    step();
    rst_i = 1'b1;
    step();
  endtask

  // Reference frame: header, MSB-first x/y/z, XOR of the twelve payload bytes.
  task automatic fill_exp(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    logic [95:0] p;
    logic [7:0]  cs;
    p  = {x, y, z};
    cs = 8'h00;
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'h5A;
    for (int i = 0; i < 12; i++) begin
      exp_bytes[2 + i] = p[95 - 8*i -: 8];
      cs = cs ^ p[95 - 8*i -: 8];
    end
    exp_bytes[14] = cs;
  endtask

  // Present one sample for one edge, then scramble the inputs so any leak of
  // live inputs into the frame shows up as a wrong byte.
  task automatic capture(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    xn_i = x; yn_i = y; zn_i = z;
    start_i = 1'b1;
    sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    xn_i = ~x;
    yn_i = x ^ 32'h5A5A_5A5A;
    zn_i = 32'hDEAD_BEEF;
  endtask

  // Walk one frame against exp_bytes. stall: ready pattern 1,0,0 repeating.
  // start_off_at: byte index at which start_i drops (-1: never).
  // chain: offer a new sample (cx/cy/cz) exactly on the checksum transfer.
  task automatic run_frame(input string tag, input bit stall, input int start_off_at,
                           input bit chain, input logic [31:0] cx,
                           input logic [31:0] cy, input logic [31:0] cz);
    int   k;
    int   c;
    logic rdy;
    k = 0;
    c = 0;
    while (k < FL && c < 200) begin
      rdy = stall ? logic'(c % 3 == 0) : 1'b1;
      tx_ready_i = rdy;
      if (k == start_off_at) start_i = 1'b0;
      if (chain && k == FL - 1) begin
        sample_valid_i = 1'b1;
        xn_i = cx; yn_i = cy; zn_i = cz;
      end
      check({tag, "_valid"}, 16'(tx_valid_o), 16'd1);
      check({tag, "_byte"}, 16'(tx_data_o), 16'(exp_bytes[k]));
      step();
      c++;
      if (rdy) k++;
    end
    check({tag, "_bytes_sent"}, 16'(k), 16'(FL));
    sample_valid_i = 1'b0;
    tx_ready_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0;
    start_i = 1'b0;
    sample_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    xn_i = '0; yn_i = '0; zn_i = '0;

    // Reset state while rst_i is held low.
    #12;
    check("rst_valid", 16'(tx_valid_o), 16'd0);
    check("rst_data", 16'(tx_data_o), 16'h0000);
    check("rst_busy", 16'(busy_o), 16'd0);
    check("rst_drop", drop_cnt_o, 16'h0000);
    rst_i = 1'b1;
    step();

    // Basic frame, ready always high, hand-computed bytes.
    exp_bytes = '{8'hA5, 8'h5A, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h40,
                  8'h00, 8'h00, 8'h00, 8'hA0, 8'h00, 8'h00, 8'hC0};
    capture(32'h0020_0000, 32'h0040_0000, 32'h00A0_0000);
    run_frame("basic", 1'b0, -1, 1'b0, '0, '0, '0);
    check("basic_busy_after", 16'(busy_o), 16'd0);
    check("basic_valid_after", 16'(tx_valid_o), 16'd0);

    // Same sample with a stalling sink; bytes must hold through every stall.
    capture(32'h0020_0000, 32'h0040_0000, 32'h00A0_0000);
    run_frame("stall", 1'b1, -1, 1'b0, '0, '0, '0);
    check("stall_busy_after", 16'(busy_o), 16'd0);

    // Sample selected on the checksum transfer chains straight into HDR0.
    fill_exp(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C);
    capture(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C);
    run_frame("chainA", 1'b0, -1, 1'b1, 32'hCAFE_0001, 32'h8000_0002, 32'h7FFF_FFFF);
    xn_i = '0; yn_i = '1; zn_i = '0;
    check("chain_valid", 16'(tx_valid_o), 16'd1);
    check("chain_hdr0", 16'(tx_data_o), 16'h00A5);
    check("chain_drop", drop_cnt_o, 16'h0000);
    fill_exp(32'hCAFE_0001, 32'h8000_0002, 32'h7FFF_FFFF);
    run_frame("chainB", 1'b0, -1, 1'b0, '0, '0, '0);
    check("chainB_busy_after", 16'(busy_o), 16'd0);

    // Strobe every 2 cycles: captures at edges 0,16,32,48 -> 32-4 = 28 drops.
    do_reset();
    start_i = 1'b1;
    for (int c = 0; c < 64; c++) begin
      sample_valid_i = (c % 2 == 0);
      xn_i = 32'(c); yn_i = 32'(c); zn_i = 32'(c);
      step();
      if (c == 15) check("dense_idle_gap", 16'(busy_o), 16'd0);
    end
    sample_valid_i = 1'b0;
    check("dense_drop", drop_cnt_o, 16'd28);
    check("dense_busy_end", 16'(busy_o), 16'd0);

    // Decim=4: 16 samples every 4 cycles -> frames for samples 0,4,8,12.
    do_reset();
    mon4.delete();
    mon_en = 1'b1;
    start_i = 1'b1;
    for (int c = 0; c < 64; c++) begin
      sample_valid_i = (c % 4 == 0);
      xn_i = 32'h1000_0000 | 32'(c / 4);
      yn_i = 32'h2000_0000 | 32'(c / 4);
      zn_i = 32'h3000_0000 | (32'(c / 4) << 8);
      step();
    end
    sample_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) step();
    mon_en = 1'b0;
    check("decim_nbytes", 16'(mon4.size()), 16'(4 * FL));
    check("decim_drop", d4_drop, 16'h0000);
    if (mon4.size() == 4 * FL) begin
      for (int f = 0; f < 4; f++) begin
        fill_exp(32'h1000_0000 | 32'(4 * f), 32'h2000_0000 | 32'(4 * f),
                 32'h3000_0000 | (32'(4 * f) << 8));
        for (int i = 0; i < FL; i++) check("decim_byte", 16'(mon4[f*FL + i]), 16'(exp_bytes[i]));
      end
    end

    // Reset mid-frame at byte 6 aborts the frame and clears the drop count.
    do_reset();
    fill_exp(32'h1234_5678, 32'h0, 32'h0);
    capture(32'h1234_5678, 32'h0, 32'h0);
    sample_valid_i = 1'b1;
    start_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    check("abort_drop_before", drop_cnt_o, 16'd1);
    for (int i = 0; i < 4; i++) step();
    check("abort_byte6", 16'(tx_data_o), 16'h0078);
    rst_i = 1'b0;
    #1;
    check("abort_valid", 16'(tx_valid_o), 16'd0);
    check("abort_busy", 16'(busy_o), 16'd0);
    check("abort_data", 16'(tx_data_o), 16'h0000);
    check("abort_drop", drop_cnt_o, 16'h0000);
    #3;
    rst_i = 1'b1;
    step();
    capture(32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
    check("restart_valid", 16'(tx_valid_o), 16'd1);
    check("restart_hdr0", 16'(tx_data_o), 16'h00A5);
    check("restart_drop", drop_cnt_o, 16'h0000);

    // start_i dropped after HDR1: frame completes, later strobes are ignored.
    do_reset();
    fill_exp(32'hFFFF_FFFF, 32'h0102_0304, 32'h8080_8080);
    capture(32'hFFFF_FFFF, 32'h0102_0304, 32'h8080_8080);
    run_frame("stopmid", 1'b0, 2, 1'b0, '0, '0, '0);
    for (int c = 0; c < 20; c++) begin
      sample_valid_i = 1'b1;
      step();
      check("stopped_valid", 16'(tx_valid_o), 16'd0);
    end
    sample_valid_i = 1'b0;
    check("stopped_drop", drop_cnt_o, 16'h0000);
    check("stopped_busy", 16'(busy_o), 16'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
